// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory request/response port, the decode-side
// valid/ready output and the redirect input of the fetch queue.
//   master : fetch queue side (drives ireq_* and out_*)
//   slave  : environment side (memory, decode, redirect source)
interface fetch_queue_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pcplus4;
  logic        out_adel;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_instr, out_pcplus4, out_adel,
    input  ireq_ready, iresp_valid, iresp_data, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_instr, out_pcplus4, out_adel,
    output ireq_ready, iresp_valid, iresp_data, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: generates fetch PCs, issues single-word instruction reads (one outstanding),
// buffers returned words and presents {raw_instr, pcplus4, adel} to decode in program order.
// Ports:
//   clk    - clock
//   resetn - asynchronous active-low reset
//   bus    - fetch_queue_if.master: ireq_* (memory request), iresp_* (memory response),
//            out_* / out_ready (decode handshake), redirect_* (flush and restart)
// Build option: define FETCH_BYPASS_EN to forward a response straight to out_* when the
// queue is empty (consumed without a write if out_ready is high).
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'hbfc0_0000
) (
  input logic clk,
  input logic resetn,
  fetch_queue_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_drop, w_drop_next;
  logic        r_adel_done, w_adel_done_next;

  logic [31:0] r_instr [DEPTH];
  logic [31:0] r_pcp4  [DEPTH];
  logic        r_adel  [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;

  logic        w_full, w_head_valid, w_aligned, w_redirect;
  logic        w_req, w_issue, w_resp, w_bypass, w_deq;
  logic        w_enq_resp, w_enq_adel, w_enq;
  logic [31:0] w_pc_plus4, w_enq_instr;

  assign w_redirect   = bus.redirect_valid;
  assign w_full       = (r_count == (PW+1)'(DEPTH));
  assign w_head_valid = (r_count != '0);
  assign w_aligned    = (r_pc[1:0] == 2'b00);
  assign w_pc_plus4   = r_pc + 32'd4;

  // resetn gating keeps the request low while reset is asserted.
  assign w_req   = resetn && (r_state == StIdle) && w_aligned && !w_full && !w_redirect;
  assign w_issue = w_req && bus.ireq_ready;
  assign w_resp  = (r_state == StWait) && bus.iresp_valid;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = !w_head_valid && w_resp && !r_drop && !w_redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_deq      = w_head_valid && bus.out_ready && !w_redirect;
  assign w_enq_resp = w_resp && !r_drop && !w_redirect && !(w_bypass && bus.out_ready);
  // A misaligned PC produces a single address-error entry, then fetch waits for a redirect.
  assign w_enq_adel = (r_state == StIdle) && !w_aligned && !r_adel_done && !w_redirect;
  assign w_enq      = (w_enq_resp || w_enq_adel) && !w_full;
  assign w_enq_instr = w_enq_adel ? 32'h0 : bus.iresp_data;

  assign bus.ireq_valid  = w_req;
  assign bus.ireq_addr   = r_pc;
  assign bus.out_valid   = w_head_valid || w_bypass;
  assign bus.out_instr   = w_bypass ? bus.iresp_data : r_instr[r_rptr];
  assign bus.out_pcplus4 = w_bypass ? w_pc_plus4     : r_pcp4[r_rptr];
  assign bus.out_adel    = w_bypass ? 1'b0           : r_adel[r_rptr];

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_drop_next      = r_drop;
    w_adel_done_next = r_adel_done;
    if (w_redirect) begin
      w_pc_next        = bus.redirect_pc;
      w_adel_done_next = 1'b0;
      // A response arriving in the redirect cycle is the pending one; it is simply void.
      if ((r_state == StWait) && !bus.iresp_valid) begin
        w_state_next = StWait;
        w_drop_next  = 1'b1;
      end else begin
        w_state_next = StIdle;
        w_drop_next  = 1'b0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_issue) w_state_next = StWait;
          if (w_enq_adel && !w_full) w_adel_done_next = 1'b1;
        end
        StWait: begin
          if (bus.iresp_valid) begin
            w_state_next = StIdle;
            if (r_drop) w_drop_next = 1'b0;
            else        w_pc_next   = w_pc_plus4;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_pc        <= PC_RESET;
      r_drop      <= 1'b0;
      r_adel_done <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_drop      <= w_drop_next;
      r_adel_done <= w_adel_done_next;
      if (w_redirect) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_enq) r_wptr <= r_wptr + 1'b1;
        if (w_deq) r_rptr <= r_rptr + 1'b1;
        if (w_enq && !w_deq)      r_count <= r_count + 1'b1;
        else if (!w_enq && w_deq) r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pcp4[i]  <= '0;
        r_adel[i]  <= 1'b0;
      end
    end else if (w_enq) begin
      r_instr[r_wptr] <= w_enq_instr;
      r_pcp4[r_wptr]  <= w_pc_plus4;
      r_adel[r_wptr]  <= w_enq_adel;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: per-cycle directed vectors for fetch_queue (DEPTH=4). Each row gives the
// inputs for one cycle and the outputs expected in that cycle; the memory returns
// addr ^ 32'hffff_ffff, so an entry with PC+4 = p carries instruction ~(p-4).
module tb_fetch_queue;

  localparam logic [31:0] B = 32'hbfc0_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus_if ();

  fetch_queue #(.DEPTH(4), .PC_RESET(B)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if.master)
  );

  typedef struct {
    logic        rdy;   // ireq_ready
    logic        rv;    // iresp_valid
    logic [31:0] ra;    // address whose word is returned
    logic        ordy;  // out_ready
    logic        xv;    // redirect_valid
    logic [31:0] xpc;   // redirect_pc
    logic        erv;   // expected ireq_valid
    logic [31:0] era;   // expected ireq_addr (checked when erv)
    logic        eov;   // expected out_valid
    logic [31:0] ep4;   // expected out_pcplus4 (checked when eov)
    logic        eadel; // expected out_adel (checked when eov)
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] ra, logic ordy, logic xv,
                              logic [31:0] xpc, logic erv, logic [31:0] era, logic eov,
                              logic [31:0] ep4, logic eadel);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.ra = ra; v.ordy = ordy; v.xv = xv; v.xpc = xpc;
    v.erv = erv; v.era = era; v.eov = eov; v.ep4 = ep4; v.eadel = eadel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd, input logic ordy,
                       input logic xv, input logic [31:0] xpc);
    bus_if.ireq_ready     = rdy;
    bus_if.iresp_valid    = rv;
    bus_if.iresp_data     = rd;
    bus_if.out_ready      = ordy;
    bus_if.redirect_valid = xv;
    bus_if.redirect_pc    = xpc;
  endtask

  initial begin
    logic [31:0] exp_instr;
    // Fill to DEPTH with decode stalled, then drain and resume at bfc00010.
    vecs.push_back(mk(1,0,0,0,0,0,          1,B,      0,0,0));
    vecs.push_back(mk(1,1,B,0,0,0,          0,0,      0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,          1,B+4,    1,B+4,0));
    vecs.push_back(mk(1,1,B+4,0,0,0,        0,0,      1,B+4,0));
    vecs.push_back(mk(1,0,0,0,0,0,          1,B+8,    1,B+4,0));
    vecs.push_back(mk(1,1,B+8,0,0,0,        0,0,      1,B+4,0));
    vecs.push_back(mk(1,0,0,0,0,0,          1,B+12,   1,B+4,0));
    vecs.push_back(mk(1,1,B+12,0,0,0,       0,0,      1,B+4,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,0,0, 0,0, 1,B+4,0));
    vecs.push_back(mk(1,0,0,1,0,0,          0,0,      1,B+4,0));
    vecs.push_back(mk(1,0,0,1,0,0,          1,B+16,   1,B+8,0));
    vecs.push_back(mk(1,1,B+16,1,0,0,       0,0,      1,B+12,0));
    vecs.push_back(mk(1,0,0,1,0,0,          1,B+20,   1,B+16,0));
    vecs.push_back(mk(1,1,B+20,1,0,0,       0,0,      1,B+20,0));
    vecs.push_back(mk(1,0,0,1,0,0,          1,B+24,   1,B+24,0));
    // Redirect while waiting: late response is dropped.
    vecs.push_back(mk(1,0,0,1,1,32'h8000_0100, 0,0,   0,0,0));
    vecs.push_back(mk(1,1,B+24,1,0,0,       0,0,      0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,          1,32'h8000_0100, 0,0,0));
    vecs.push_back(mk(1,1,32'h8000_0100,1,0,0, 0,0,   0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,          1,32'h8000_0104, 1,32'h8000_0104,0));
    // Unaccepted request withdrawn by a redirect to a misaligned PC.
    vecs.push_back(mk(0,0,0,1,1,32'h8000_0102, 0,0,   0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,          0,0,      0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,          0,0,      1,32'h8000_0106,1));
    vecs.push_back(mk(1,0,0,1,0,0,          0,0,      0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,          0,0,      0,0,0));
    vecs.push_back(mk(1,0,0,1,1,B,          0,0,      0,0,0));
    // Build count=2, dequeue+enqueue together, then redirect with both pending.
    vecs.push_back(mk(1,0,0,0,0,0,          1,B,      0,0,0));
    vecs.push_back(mk(1,1,B,0,0,0,          0,0,      0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,          1,B+4,    1,B+4,0));
    vecs.push_back(mk(1,1,B+4,0,0,0,        0,0,      1,B+4,0));
    vecs.push_back(mk(1,0,0,0,0,0,          1,B+8,    1,B+4,0));
    vecs.push_back(mk(1,1,B+8,1,0,0,        0,0,      1,B+4,0));
    vecs.push_back(mk(1,0,0,0,0,0,          1,B+12,   1,B+8,0));
    vecs.push_back(mk(1,1,B+12,1,1,32'h8000_0200, 0,0, 1,B+8,0));
    vecs.push_back(mk(0,0,0,1,0,0,          1,32'h8000_0200, 0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,          1,32'h8000_0200, 0,0,0));
    vecs.push_back(mk(1,1,32'h8000_0200,1,0,0, 0,0,   0,0,0));
    vecs.push_back(mk(1,0,0,1,0,0,          1,32'h8000_0204, 1,32'h8000_0204,0));
    // Back-to-back redirects while waiting: last wins, one late response dropped.
    vecs.push_back(mk(1,0,0,1,1,32'h8000_0400, 0,0,   0,0,0));
    vecs.push_back(mk(1,0,0,1,1,32'h8000_0500, 0,0,   0,0,0));
    vecs.push_back(mk(1,1,32'h8000_0204,1,0,0, 0,0,   0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,          1,32'h8000_0500, 0,0,0));

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset ireq_valid",  32'(bus_if.ireq_valid),  32'h0);
    chk("reset out_valid",   32'(bus_if.out_valid),   32'h0);
    chk("reset out_instr",   bus_if.out_instr,        32'h0);
    chk("reset out_pcplus4", bus_if.out_pcplus4,      32'h0);
    chk("reset out_adel",    32'(bus_if.out_adel),    32'h0);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].rv, ~vecs[i].ra, vecs[i].ordy, vecs[i].xv, vecs[i].xpc);
      #1;
      chk($sformatf("row%0d ireq_valid", i), 32'(bus_if.ireq_valid), 32'(vecs[i].erv));
      if (vecs[i].erv) chk($sformatf("row%0d ireq_addr", i), bus_if.ireq_addr, vecs[i].era);
      chk($sformatf("row%0d out_valid", i), 32'(bus_if.out_valid), 32'(vecs[i].eov));
      if (vecs[i].eov) begin
        exp_instr = vecs[i].eadel ? 32'h0 : ~(vecs[i].ep4 - 32'd4);
        chk($sformatf("row%0d out_pcplus4", i), bus_if.out_pcplus4, vecs[i].ep4);
        chk($sformatf("row%0d out_adel", i), 32'(bus_if.out_adel), 32'(vecs[i].eadel));
        chk($sformatf("row%0d out_instr", i), bus_if.out_instr, exp_instr);
      end
      @(negedge clk);
    end

    // Response-to-out_valid latency with an empty queue (fetch at 80000500).
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 1, 32'h1234_5678, 1, 0, 0);
    #1;
`ifdef FETCH_BYPASS_EN
    chk("bypass same-cycle out_valid", 32'(bus_if.out_valid), 32'h1);
    chk("bypass same-cycle out_instr", bus_if.out_instr, 32'h1234_5678);
    chk("bypass same-cycle pcplus4", bus_if.out_pcplus4, 32'h8000_0504);
`else
    chk("latency same-cycle out_valid", 32'(bus_if.out_valid), 32'h0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0);
    #1;
`ifdef FETCH_BYPASS_EN
    chk("bypass consumed out_valid", 32'(bus_if.out_valid), 32'h0);
`else
    chk("latency next-cycle out_valid", 32'(bus_if.out_valid), 32'h1);
    chk("latency next-cycle out_instr", bus_if.out_instr, 32'h1234_5678);
    chk("latency next-cycle pcplus4", bus_if.out_pcplus4, 32'h8000_0504);
`endif
    chk("resume ireq_addr", bus_if.ireq_addr, 32'h8000_0504);

    // Asynchronous reset with a request outstanding.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    #1;
    chk("midreset ireq_valid", 32'(bus_if.ireq_valid), 32'h0);
    chk("midreset out_valid",  32'(bus_if.out_valid),  32'h0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("postreset ireq_valid", 32'(bus_if.ireq_valid), 32'h1);
    chk("postreset ireq_addr",  bus_if.ireq_addr,       B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
